// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and the calculator FSM:
// scanner states, operator key codes and the row/column to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  // Row 0 is the top row, column 0 the left column; the lowest active column wins.
  function automatic logic [3:0] key_encode(input logic [1:0] row, input logic [3:0] col_n);
    logic [1:0] col;
    logic [3:0] code;
    col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_n[c]) col = 2'(c);
    end
    if (col == 2'd3) begin
      case (row)
        2'd0:    code = KEY_ADD;
        2'd1:    code = KEY_SUB;
        2'd2:    code = KEY_MUL;
        default: code = KEY_DIV;
      endcase
    end else if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_CLR;
        2'd1:    code = 4'h0;
        default: code = KEY_EQ;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so an
// idle pulled-up bus reads as inactive straight out of reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot active-low row drive, debounced press and
// release, one key_press strobe per physical press with the encoded key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_press,
  output logic       key_held
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_TICKS);

  logic [3:0]        col_sync;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  state_e            state_q, state_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        pat_q, pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_press_q, key_press_d;
  logic              key_held_q, key_held_d;
  logic              col_idle;

  sync_2ff #(.WIDTH(4)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_n),
    .q     (col_sync)
  );

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_press_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_inc     = cnt_q + CNT_W'(1);
    col_idle    = (col_sync == 4'hF);

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_idle) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            pat_d = col_sync;
            cnt_d = CNT_W'(1);
            if (DEBOUNCE_TICKS == 1) begin
              state_d     = PRESSED;
              key_press_d = 1'b1;
              key_held_d  = 1'b1;
              key_code_d  = key_encode(row_idx_q, col_sync);
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (col_sync == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d     = PRESSED;
              key_press_d = 1'b1;
              key_held_d  = 1'b1;
              key_code_d  = key_encode(row_idx_q, pat_q);
            end
          end else begin
            state_d   = SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        PRESSED: begin
          // Only a fully idle column bus counts; extra keys in this row are ignored.
          if (col_idle) begin
            cnt_d = CNT_W'(1);
            if (DEBOUNCE_TICKS == 1) begin
              state_d    = SCAN;
              key_held_d = 1'b0;
              row_idx_d  = row_idx_q + 2'd1;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (col_idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d    = SCAN;
              key_held_d = 1'b0;
              row_idx_d  = row_idx_q + 2'd1;
            end
          end else begin
            // Bounce while releasing: fall back without a new strobe.
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      pat_q       <= 4'hF;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_press_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_press_q <= key_press_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_n     = ~(4'b0001 << row_idx_q);
  assign key_code  = key_code_q;
  assign key_press = key_press_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives col_n from row_n and
// the set of pressed keys; expectations come from the key layout and timing rules.
module tb_keypad_scanner;

  localparam int SD  = 8;
  localparam int DT  = 3;
  localparam int LAT = SD * DT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_press;
  logic       key_held;

  logic [15:0] keys = 16'h0;
  logic        force_open = 1'b0;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int strobe_cnt = 0;
  int double_cnt = 0;
  int strobe_lat = -1;
  int last_change = 0;
  int held_fall_cyc = -1;
  int scan_base = 0;
  logic [3:0] last_code = 4'h0;
  logic [3:0] prev_row = 4'hF;
  logic       prev_press = 1'b0;
  logic       prev_held = 1'b0;

  // Key faces in layout order "123A 456B 789C *0#D".
  int key_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_press (key_press),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
    if (force_open) col_n = 4'hF;
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (row_n !== prev_row) begin
      last_change = cyc;
      prev_row = row_n;
    end
    if (key_press === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_code = key_code;
      strobe_lat = cyc - last_change;
      if (prev_press === 1'b1) double_cnt = double_cnt + 1;
    end
    prev_press = key_press;
    if (prev_held === 1'b1 && key_held === 1'b0) held_fall_cyc = cyc;
    prev_held = key_held;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_row_change(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (last_change == cyc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(input int start, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (strobe_cnt != start) break;
    end
  endtask

  task automatic release_and_check(input string name);
    int rel;
    int d;
    held_fall_cyc = -1;
    keys = 16'h0;
    rel = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_held === 1'b0) break;
    end
    d = held_fall_cyc - rel;
    tests++;
    if (key_held !== 1'b0 || d < 19 || d > 26) begin
      fails++;
      $display("FAIL %s held_release: held=%b fall_delay=%0d required 0 and 19..26", name, key_held, d);
    end
  endtask

  task automatic press_and_check(input logic [15:0] mask, input logic [3:0] exp,
                                 input int hold, input string name);
    bit ok;
    int start;
    wait_row_change(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s row_step: no row change seen, required one within 20 clk", name);
    end
    start = strobe_cnt;
    keys = mask;
    wait_strobe(start, 150);
    tests++;
    if (strobe_cnt != start + 1) begin
      fails++;
      $display("FAIL %s strobe_count: got %0d required 1", name, strobe_cnt - start);
    end
    tests++;
    if (last_code !== exp) begin
      fails++;
      $display("FAIL %s key_code: got %h required %h", name, last_code, exp);
    end
    tests++;
    if (strobe_lat != LAT) begin
      fails++;
      $display("FAIL %s latency: got %0d required %0d clk after row select", name, strobe_lat, LAT);
    end
    tests++;
    if (key_held !== 1'b1) begin
      fails++;
      $display("FAIL %s held_rise: got %b required 1", name, key_held);
    end
    repeat (hold) @(negedge clk);
    release_and_check(name);
    tests++;
    if (strobe_cnt != start + 1) begin
      fails++;
      $display("FAIL %s repeat_strobe: got %0d strobes required 1", name, strobe_cnt - start);
    end
    wait_row_change(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s scan_resume: no row change after release", name);
    end
    $display("[TB] %s: mask=%h code=%h latency=%0d", name, mask, last_code, strobe_lat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (row_n !== 4'b1110) begin
      fails++; $display("FAIL reset row_n: got %b required 1110", row_n);
    end
    tests++;
    if (key_code !== 4'h0) begin
      fails++; $display("FAIL reset key_code: got %h required 0", key_code);
    end
    tests++;
    if (key_press !== 1'b0) begin
      fails++; $display("FAIL reset key_press: got %b required 0", key_press);
    end
    tests++;
    if (key_held !== 1'b0) begin
      fails++; $display("FAIL reset key_held: got %b required 0", key_held);
    end
    reset = 1'b0;
    scan_base = cyc;
    $display("[TB] reset: row_n=%b key_code=%h", row_n, key_code);
  endtask

  task automatic test_scan();
    int n;
    logic [3:0] exp_row;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n = cyc - scan_base;
      exp_row = ~(4'b0001 << ((n / SD) % 4));
      tests++;
      if (row_n !== exp_row) begin
        fails++;
        $display("FAIL scan row_n at clk %0d: got %b required %b", n, row_n, exp_row);
      end
    end
    tests++;
    if (strobe_cnt != 0 || key_held !== 1'b0 || key_code !== 4'h0) begin
      fails++;
      $display("FAIL scan idle_outputs: strobes=%0d held=%b code=%h required 0 0 0", strobe_cnt, key_held, key_code);
    end
    $display("[TB] scan: 40 clk idle, strobes=%0d", strobe_cnt);
  endtask

  task automatic test_bounce();
    logic [15:0] mask;
    int start;
    bit found;
    mask = 16'h1 << 14;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (row_n === 4'b0111 && last_change == cyc) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL bounce row3_wait: row 3 not selected within 60 clk");
    end
    start = strobe_cnt;
    keys = mask;
    for (int t = 0; t < 8; t++) begin
      repeat (5) @(negedge clk);
      keys = keys ^ mask;
    end
    tests++;
    if (strobe_cnt != start) begin
      fails++; $display("FAIL bounce quiet: got %0d strobes required 0", strobe_cnt - start);
    end
    wait_strobe(start, 150);
    tests++;
    if (strobe_cnt != start + 1 || last_code !== 4'hF) begin
      fails++;
      $display("FAIL bounce settle: strobes=%0d code=%h required 1 f", strobe_cnt - start, last_code);
    end
    release_and_check("bounce");
    $display("[TB] bounce: code=%h strobes=%0d", last_code, strobe_cnt - start);
  endtask

  task automatic test_release_bounce();
    bit ok;
    bit dropped;
    int start;
    wait_row_change(ok);
    start = strobe_cnt;
    keys = 16'h1 << 3;
    wait_strobe(start, 150);
    tests++;
    if (strobe_cnt != start + 1 || last_code !== 4'hA) begin
      fails++;
      $display("FAIL rel_bounce press: strobes=%0d code=%h required 1 a", strobe_cnt - start, last_code);
    end
    repeat (20) @(negedge clk);
    dropped = 1'b0;
    force_open = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 7) force_open = 1'b0;
      if (key_held !== 1'b1) dropped = 1'b1;
    end
    tests++;
    if (dropped) begin
      fails++; $display("FAIL rel_bounce held: got a drop of key_held required steady 1");
    end
    tests++;
    if (strobe_cnt != start + 1) begin
      fails++; $display("FAIL rel_bounce repeat: got %0d strobes required 1", strobe_cnt - start);
    end
    release_and_check("rel_bounce");
    $display("[TB] release bounce: code=%h strobes=%0d", last_code, strobe_cnt - start);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    int start;
    int arr;
    wait_row_change(ok);
    start = strobe_cnt;
    keys = 16'h1 << 13;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (row_n === 4'b0111) begin
        found = 1'b1;
        break;
      end
    end
    arr = last_change;
    for (int i = 0; i < 40; i++) begin
      if (cyc >= arr + LAT - 1) break;
      @(negedge clk);
    end
    tests++;
    if (!found || cyc != arr + LAT - 1 || strobe_cnt != start) begin
      fails++;
      $display("FAIL reset_mid setup: found=%b at=%0d required %0d strobes=%0d", found, cyc - arr, LAT - 1, strobe_cnt - start);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (row_n !== 4'b1110 || key_code !== 4'h0 || key_press !== 1'b0 || key_held !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid outputs: row=%b code=%h press=%b held=%b required 1110 0 0 0", row_n, key_code, key_press, key_held);
    end
    tests++;
    if (strobe_cnt != start) begin
      fails++; $display("FAIL reset_mid dropped: got %0d strobes required 0", strobe_cnt - start);
    end
    wait_strobe(start, 150);
    tests++;
    if (strobe_cnt != start + 1 || last_code !== 4'h0 || strobe_lat != LAT) begin
      fails++;
      $display("FAIL reset_mid repress: strobes=%0d code=%h lat=%0d required 1 0 %0d", strobe_cnt - start, last_code, strobe_lat, LAT);
    end
    release_and_check("reset_mid");
    $display("[TB] reset mid: code=%h latency=%0d", last_code, strobe_lat);
  endtask

  task automatic test_random();
    int idx;
    for (int k = 0; k < 6; k++) begin
      idx = $urandom_range(0, 15);
      press_and_check(16'h1 << idx, 4'(key_tab[idx]), $urandom_range(0, 40), "random");
    end
  endtask

  task automatic test_strobe_width();
    tests++;
    if (double_cnt != 0) begin
      fails++; $display("FAIL strobe_width: got %0d multi-clk strobes required 0", double_cnt);
    end
    $display("[TB] strobe width: total strobes=%0d", strobe_cnt);
  endtask

  initial begin
    test_reset();
    test_scan();
    press_and_check(16'h1 << 5, 4'h5, 200, "key5");
    test_bounce();
    test_release_bounce();
    press_and_check((16'h1 << 8) | (16'h1 << 10), 4'h7, 30, "two_keys");
    test_reset_mid();
    test_random();
    test_strobe_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
